im_expansion: RTL and testbench

// Inverse of the 4x4 averaging compressor: reads a compressed frame (default 160x120) from source

---
 rtl/im_expansion.sv | 172 +++++++++++++++++
 tb/tb_im_expansion.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_expansion.sv
// rtl/im_expansion.sv - nearest-neighbour frame expander: each source pixel becomes a pAREA_WIDTH x pAREA_HEIGHT block
module im_expansion #(
    parameter int pIN_IM_WIDTH  = 160,
    parameter int pIN_IM_HEIGHT = 120,
    parameter int pAREA_WIDTH   = 4,
    parameter int pAREA_HEIGHT  = 4,
    parameter int pDATA_W       = 24,
    parameter int pRD_LAT       = 1,
    localparam int AW_IN  = $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int AW_OUT = $clog2(pIN_IM_WIDTH * pAREA_WIDTH * pIN_IM_HEIGHT * pAREA_HEIGHT)
) (
    input  logic                iclk,
    input  logic                irst_n,
    output logic [AW_IN-1:0]    oaddr_rd,
    output logic                omem_rd_en,
    input  logic [pDATA_W-1:0]  idata_rd,
    output logic [pDATA_W-1:0]  odata_wr,
    output logic [AW_OUT-1:0]   oaddr_wr,
    output logic                omem_wr_en,
    input  logic                iwr_ready,
    input  logic [AW_IN-1:0]    isrc_start_ptr,
    input  logic [AW_OUT-1:0]   idst_start_ptr,
    input  logic                istart_work,
    output logic                omodule_work_f,
    output logic                omodule_done_f
);

    localparam int OUT_W = pIN_IM_WIDTH * pAREA_WIDTH;
    localparam int SXW   = (pIN_IM_WIDTH  > 1) ? $clog2(pIN_IM_WIDTH)  : 1;
    localparam int SYW   = (pIN_IM_HEIGHT > 1) ? $clog2(pIN_IM_HEIGHT) : 1;
    localparam int CW    = (pAREA_WIDTH   > 1) ? $clog2(pAREA_WIDTH)   : 1;
    localparam int RW    = (pAREA_HEIGHT  > 1) ? $clog2(pAREA_HEIGHT)  : 1;
    localparam int WTW   = (pRD_LAT > 2) ? $clog2(pRD_LAT - 1) : 1;

    localparam logic [SXW-1:0] SX_LAST  = SXW'(pIN_IM_WIDTH - 1);
    localparam logic [SYW-1:0] SY_LAST  = SYW'(pIN_IM_HEIGHT - 1);
    localparam logic [CW-1:0]  C_LAST   = CW'(pAREA_WIDTH - 1);
    localparam logic [RW-1:0]  R_LAST   = RW'(pAREA_HEIGHT - 1);
    localparam logic [WTW-1:0] WAIT_LAST = WTW'((pRD_LAT > 1) ? pRD_LAT - 2 : 0);
    localparam logic           HAS_WAIT = (pRD_LAT > 1);

    // Address strides: next pixel in a block row, next block row, next block, next source row.
    localparam logic [AW_OUT-1:0] ONE_OUT   = AW_OUT'(1);
    localparam logic [AW_OUT-1:0] ROW_STEP  = AW_OUT'(OUT_W - pAREA_WIDTH + 1);
    localparam logic [AW_OUT-1:0] BLK_STEP  = AW_OUT'(pAREA_WIDTH);
    localparam logic [AW_OUT-1:0] LINE_STEP = AW_OUT'(pAREA_WIDTH + (pAREA_HEIGHT - 1) * OUT_W);
    localparam logic [AW_IN-1:0]  ONE_IN    = AW_IN'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [AW_IN-1:0]    rd_addr;
    logic [AW_OUT-1:0]   blk_base;
    logic [AW_OUT-1:0]   wr_addr;
    logic [pDATA_W-1:0]  pixel;
    logic [SXW-1:0]      sx;
    logic [SYW-1:0]      sy;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [WTW-1:0]      wait_cnt;

    logic last_col;
    logic last_beat;
    logic last_x;
    logic last_y;

    assign last_col  = (col == C_LAST);
    assign last_beat = last_col && (row == R_LAST);
    assign last_x    = (sx == SX_LAST);
    assign last_y    = (sy == SY_LAST);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (istart_work) state_nxt = ST_READ;
            ST_READ:  state_nxt = HAS_WAIT ? ST_WAIT : ST_LATCH;
            ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (iwr_ready && last_beat) begin
                    state_nxt = (last_x && last_y) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rd_addr  <= '0;
            blk_base <= '0;
            wr_addr  <= '0;
            pixel    <= '0;
            sx       <= '0;
            sy       <= '0;
            col      <= '0;
            row      <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (istart_work) begin
                        rd_addr  <= isrc_start_ptr;
                        blk_base <= idst_start_ptr;
                        sx       <= '0;
                        sy       <= '0;
                    end
                end
                ST_READ: wait_cnt <= '0;
                ST_WAIT: wait_cnt <= wait_cnt + WTW'(1);
                ST_LATCH: begin
                    pixel   <= idata_rd;
                    wr_addr <= blk_base;
                    col     <= '0;
                    row     <= '0;
                end
                ST_WRITE: begin
                    if (iwr_ready) begin
                        if (last_col) begin
                            col     <= '0;
                            row     <= row + RW'(1);
                            wr_addr <= wr_addr + ROW_STEP;
                        end else begin
                            col     <= col + CW'(1);
                            wr_addr <= wr_addr + ONE_OUT;
                        end
                        // Block finished: step source pointer and block base to the next pixel.
                        if (last_beat) begin
                            rd_addr <= rd_addr + ONE_IN;
                            if (last_x) begin
                                sx       <= '0;
                                sy       <= sy + SYW'(1);
                                blk_base <= blk_base + LINE_STEP;
                            end else begin
                                sx       <= sx + SXW'(1);
                                blk_base <= blk_base + BLK_STEP;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign oaddr_rd       = rd_addr;
    assign omem_rd_en     = (state == ST_READ);
    assign odata_wr       = pixel;
    assign oaddr_wr       = wr_addr;
    assign omem_wr_en     = (state == ST_WRITE);
    assign omodule_work_f = (state == ST_READ) || (state == ST_WAIT) ||
                            (state == ST_LATCH) || (state == ST_WRITE);
    assign omodule_done_f = (state == ST_DONE);

endmodule

// File: tb/tb_im_expansion.sv
// tb/tb_im_expansion.sv - scoreboard bench for im_expansion (small frames at latency 1 and 3, default-size prefix)
module tb_im_expansion;

    localparam int SW    = 4;
    localparam int SH    = 2;
    localparam int AREA  = 4;
    localparam int SOW   = 16;
    localparam int NPIX  = 8;
    localparam int NBEAT = 16;
    localparam int BW    = 160;
    localparam int BOW   = 640;
    localparam int BPIX  = 161;
    localparam logic [23:0] POISON = 24'hDEAD00;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int st_cyc = 0;
    initial forever @(posedge iclk) cyc++;

    function automatic logic [23:0] pix(input logic [31:0] a);
        logic [31:0] p;
        p = a * 32'h0001_0101;
        return p[23:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Two 4x2 instances sharing stimulus: index 0 read latency 1, index 1 read latency 3.
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        rand_ready;
    logic [2:0]  src_ptr;
    logic [6:0]  dst_ptr;
    logic [2:0]  raddr_v [2];
    logic        ren_v   [2];
    logic [23:0] rdata_v [2];
    logic [23:0] wdata_v [2];
    logic [6:0]  waddr_v [2];
    logic        wen_v   [2];
    logic        work_v  [2];
    logic        done_v  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_small
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [23:0] pipe [LAT];

        im_expansion #(
            .pIN_IM_WIDTH(SW), .pIN_IM_HEIGHT(SH), .pAREA_WIDTH(AREA),
            .pAREA_HEIGHT(AREA), .pDATA_W(24), .pRD_LAT(LAT)
        ) u_dut (
            .iclk(iclk), .irst_n(rst_n),
            .oaddr_rd(raddr_v[gi]), .omem_rd_en(ren_v[gi]), .idata_rd(rdata_v[gi]),
            .odata_wr(wdata_v[gi]), .oaddr_wr(waddr_v[gi]), .omem_wr_en(wen_v[gi]),
            .iwr_ready(ready), .isrc_start_ptr(src_ptr), .idst_start_ptr(dst_ptr),
            .istart_work(start), .omodule_work_f(work_v[gi]), .omodule_done_f(done_v[gi])
        );

        always @(posedge iclk) begin
            pipe[0] <= ren_v[gi] ? pix(32'(raddr_v[gi])) : POISON;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign rdata_v[gi] = pipe[LAT-1];
    end

    // Default-geometry instance.
    logic        rstb_n;
    logic        startb;
    logic [14:0] raddr_b;
    logic        ren_b;
    logic [23:0] rdata_b;
    logic [23:0] wdata_b;
    logic [18:0] waddr_b;
    logic        wen_b;
    logic        work_b;
    logic        done_b;

    im_expansion u_dut_b (
        .iclk(iclk), .irst_n(rstb_n),
        .oaddr_rd(raddr_b), .omem_rd_en(ren_b), .idata_rd(rdata_b),
        .odata_wr(wdata_b), .oaddr_wr(waddr_b), .omem_wr_en(wen_b),
        .iwr_ready(1'b1), .isrc_start_ptr(15'd100), .idst_start_ptr(19'd1000),
        .istart_work(startb), .omodule_work_f(work_b), .omodule_done_f(done_b)
    );

    always @(posedge iclk) rdata_b <= ren_b ? pix(32'(raddr_b)) : POISON;

    // Scoreboard state.
    logic [30:0] exp_q [$];
    logic [42:0] expb_q [$];
    int          wr_idx [2];
    int          rd_idx [2];
    int          done_cnt [2];
    int          done_cyc [2];
    logic        stall_v [2];
    logic [30:0] held_v [2];
    logic [2:0]  src_base;
    int          wrb_idx;
    int          rdb_idx;
    logic [18:0] b_addr [5];
    logic [14:0] b_first_rd;

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge iclk);
            #1;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [2:0]  ra;
        logic [14:0] rb;
        for (int i = 0; i < 2; i++) begin
            wr_idx[i] = 0; rd_idx[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
            stall_v[i] = 1'b0; held_v[i] = '0;
        end
        src_base = '0; wrb_idx = 0; rdb_idx = 0; b_first_rd = '0;
        for (int i = 0; i < 5; i++) b_addr[i] = '0;
        forever begin
            @(negedge iclk);
            for (int i = 0; i < 2; i++) begin
                if (rst_n === 1'b1) begin
                    if (stall_v[i])
                        check("stall_hold", {wen_v[i], waddr_v[i], wdata_v[i]}, {1'b1, held_v[i]});
                    if (ren_v[i]) begin
                        ra = src_base + 3'(rd_idx[i]);
                        check("rd_addr", raddr_v[i], ra);
                        rd_idx[i]++;
                    end
                    if (wen_v[i] && ready) begin
                        if (wr_idx[i] < exp_q.size())
                            check("wr_beat", {waddr_v[i], wdata_v[i]}, exp_q[wr_idx[i]]);
                        else
                            check("wr_extra", wr_idx[i], exp_q.size());
                        wr_idx[i]++;
                    end
                    stall_v[i] = wen_v[i] && !ready;
                    held_v[i]  = {waddr_v[i], wdata_v[i]};
                    if (done_v[i]) begin
                        done_cnt[i]++;
                        done_cyc[i] = cyc;
                    end
                end else begin
                    stall_v[i] = 1'b0;
                end
            end
            if (rstb_n === 1'b1) begin
                if (ren_b && rdb_idx < BPIX) begin
                    if (rdb_idx == 0) b_first_rd = raddr_b;
                    rb = 15'd100 + 15'(rdb_idx);
                    check("b_rd_addr", raddr_b, rb);
                    rdb_idx++;
                end
                if (wen_b && wrb_idx < expb_q.size()) begin
                    check("b_wr_beat", {waddr_b, wdata_b}, expb_q[wrb_idx]);
                    if (wrb_idx < 16 && wrb_idx % 4 == 0) b_addr[wrb_idx / 4] = waddr_b;
                    if (wrb_idx == 2560) b_addr[4] = waddr_b;
                    wrb_idx++;
                end
            end
        end
    end

    task automatic start_frame(input logic [2:0] sp, input logic [6:0] dp);
        logic [6:0] a;
        logic [2:0] s;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            wr_idx[i] = 0; rd_idx[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0; stall_v[i] = 1'b0;
        end
        src_base = sp;
        for (int sy = 0; sy < SH; sy++)
            for (int sx = 0; sx < SW; sx++)
                for (int r = 0; r < AREA; r++)
                    for (int c = 0; c < AREA; c++) begin
                        a = dp + 7'((sy * AREA + r) * SOW + sx * AREA + c);
                        s = sp + 3'(sy * SW + sx);
                        exp_q.push_back({a, pix(32'(s))});
                    end
        src_ptr = sp;
        dst_ptr = dp;
        start   = 1'b1;
        st_cyc  = cyc;
        @(posedge iclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input bit timed, input bit pulse);
        int n = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < 3000) begin
            @(posedge iclk);
            #1;
            n++;
            if (n == 5) begin
                check("work_high_0", work_v[0], 1'b1);
                check("work_high_1", work_v[1], 1'b1);
            end
            if (pulse && n == 40) begin
                src_ptr = 3'd1; dst_ptr = 7'd99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("frame_done_in_time", n < 3000, 1'b1);
        repeat (8) @(posedge iclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("done_pulses", done_cnt[i], 1);
            check("write_count", wr_idx[i], NPIX * NBEAT);
            check("read_count", rd_idx[i], NPIX);
            check("work_cleared", work_v[i], 1'b0);
            if (timed) check("done_cycle", done_cyc[i] - st_cyc, (i == 0 ? 18 : 20) * NPIX + 1);
        end
    endtask

    initial begin
        int n;
        logic [18:0] a;
        int sx;
        int sy;
        rst_n = 1'b0; rstb_n = 1'b0; start = 1'b0; startb = 1'b0;
        src_ptr = '0; dst_ptr = '0; rand_ready = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        for (int i = 0; i < 2; i++)
            check("reset_outputs", {raddr_v[i], ren_v[i], wdata_v[i], waddr_v[i], wen_v[i],
                                    work_v[i], done_v[i]}, '0);
        check("reset_outputs_b", {raddr_b, ren_b, wdata_b, waddr_b, wen_b, work_b, done_b}, '0);
        rst_n = 1'b1; rstb_n = 1'b1;
        @(posedge iclk);
        #1;

        // Plain frame, then stalled destination, then mid-frame start pulse, then wrapping pointers.
        start_frame(3'd0, 7'd0);
        wait_frame(1'b1, 1'b0);
        rand_ready = 1'b1;
        start_frame(3'd0, 7'd0);
        wait_frame(1'b0, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        start_frame(3'd0, 7'd0);
        wait_frame(1'b1, 1'b1);
        start_frame(3'd5, 7'd120);
        wait_frame(1'b1, 1'b0);

        // Asynchronous reset while both instances are writing.
        start_frame(3'd2, 7'd33);
        n = 0;
        while (!(wen_v[0] && wen_v[1]) && n < 200) begin
            @(posedge iclk);
            #2;
            n++;
        end
        check("reached_write", wen_v[0] && wen_v[1], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check("async_reset_outputs", {raddr_v[i], ren_v[i], wdata_v[i], waddr_v[i], wen_v[i],
                                          work_v[i], done_v[i]}, '0);
        repeat (2) @(posedge iclk);
        #1;
        rst_n = 1'b1;
        @(posedge iclk);
        #1;
        start_frame(3'd6, 7'd64);
        wait_frame(1'b1, 1'b0);

        // Default geometry: first 161 source pixels (one full source row plus one).
        expb_q.delete();
        for (int p = 0; p < BPIX; p++) begin
            sx = p % BW;
            sy = p / BW;
            for (int r = 0; r < AREA; r++)
                for (int c = 0; c < AREA; c++) begin
                    a = 19'd1000 + 19'((sy * AREA + r) * BOW + sx * AREA + c);
                    expb_q.push_back({a, pix(32'(100 + p))});
                end
        end
        startb = 1'b1;
        @(posedge iclk);
        #1;
        startb = 1'b0;
        n = 0;
        while (wrb_idx < BPIX * NBEAT && n < 4000) begin
            @(posedge iclk);
            #1;
            n++;
        end
        check("b_progress", wrb_idx, BPIX * NBEAT);
        check("b_first_rd", b_first_rd, 15'd100);
        check("b_row0", b_addr[0], 19'd1000);
        check("b_row1", b_addr[1], 19'd1640);
        check("b_row2", b_addr[2], 19'd2280);
        check("b_row3", b_addr[3], 19'd2920);
        check("b_next_src_row", b_addr[4], 19'd3560);
        rstb_n = 1'b0;
        repeat (2) @(posedge iclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
